// File: rtl/dma_cmd_scheduler_if.sv
// dma_cmd_scheduler_if: chunk issue/complete handshake between scheduler and transfer controller
interface dma_cmd_scheduler_if #(
  parameter int ADDR_W = 64,
  parameter int LEN_W  = 64
);
  logic              chunk_valid;
  logic              chunk_ready;
  logic [ADDR_W-1:0] chunk_src;
  logic [ADDR_W-1:0] chunk_dst;
  logic [LEN_W-1:0]  chunk_len;
  logic              chunk_last;
  logic              chunk_done;
  modport master (output chunk_valid, chunk_src, chunk_dst, chunk_len, chunk_last,
                  input  chunk_ready, chunk_done);
  modport slave  (input  chunk_valid, chunk_src, chunk_dst, chunk_len, chunk_last,
                  output chunk_ready, chunk_done);
endinterface

// File: rtl/dma_cmd_scheduler.sv
// dma_cmd_scheduler: queues DMA commands and issues them as MAX_CHUNK-bounded chunks, one outstanding
module dma_cmd_scheduler #(
  parameter int ADDR_W    = 64,
  parameter int LEN_W     = 64,
  parameter int DEPTH     = 4,
  parameter int MAX_CHUNK = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              new_cmd,
  input  logic [ADDR_W-1:0] src_start_addr,
  input  logic [ADDR_W-1:0] dst_start_addr,
  input  logic [LEN_W-1:0]  xfer_length,
  input  logic              sclr,
  input  logic              clear_irq,
  dma_cmd_scheduler_if.master chunk,
  output logic [63:0]       cmdq_status,
  output logic              busy,
  output logic              irq,
  output logic [31:0]       cmd_done_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [LEN_W-1:0] MAXL = LEN_W'(MAX_CHUNK);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;
  state_t state;
  logic [ADDR_W-1:0] q_src [DEPTH];
  logic [ADDR_W-1:0] q_dst [DEPTH];
  logic [LEN_W-1:0]  q_len [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic overflow, full, empty, push, pop, fin, lt;
  logic [LEN_W-1:0] rem, nrem, ld, clen;
  always_comb begin
    full = count == CW'(DEPTH);
    empty = count == '0;
    push = new_cmd && xfer_length != '0 && !full && !sclr;
    pop = state == IDLE && !empty && !sclr;
    nrem = rem - chunk.chunk_len;
    ld = pop ? q_len[rd_ptr] : nrem;
    lt = ld <= MAXL;
    clen = lt ? ld : MAXL;
    fin = state == WAIT && chunk.chunk_done && !sclr && nrem == '0;
    cmdq_status = {29'b0, overflow, full, empty, 16'b0, 16'(count)};
    busy = !empty || state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      q_src[wr_ptr] <= src_start_addr;
      q_dst[wr_ptr] <= dst_start_addr;
      q_len[wr_ptr] <= xfer_length;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) {wr_ptr, rd_ptr, count, overflow} <= '0;
    else if (sclr) {wr_ptr, rd_ptr, count, overflow} <= '0;
    else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (new_cmd && xfer_length != '0 && full) overflow <= 1'b1;
    end
  end
  // Working src/dst live directly in the chunk output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      chunk.chunk_valid <= 1'b0;
      chunk.chunk_src <= '0;
      chunk.chunk_dst <= '0;
      chunk.chunk_len <= '0;
      chunk.chunk_last <= 1'b0;
      rem <= '0;
      irq <= 1'b0;
      cmd_done_count <= '0;
    end else begin
      if (clear_irq) irq <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          state <= ISSUE;
          chunk.chunk_valid <= 1'b1;
          chunk.chunk_src <= q_src[rd_ptr];
          chunk.chunk_dst <= q_dst[rd_ptr];
          chunk.chunk_len <= clen;
          chunk.chunk_last <= lt;
          rem <= q_len[rd_ptr];
        end
        ISSUE: if (sclr || chunk.chunk_ready) begin
          state <= sclr ? IDLE : WAIT;
          chunk.chunk_valid <= 1'b0;
        end
        WAIT: if (sclr) state <= chunk.chunk_done ? IDLE : DRAIN;
        else if (chunk.chunk_done) begin
          rem <= nrem;
          chunk.chunk_src <= chunk.chunk_src + ADDR_W'(chunk.chunk_len);
          chunk.chunk_dst <= chunk.chunk_dst + ADDR_W'(chunk.chunk_len);
          if (fin) begin
            state <= IDLE;
            irq <= 1'b1;
            cmd_done_count <= cmd_done_count + 32'd1;
          end else begin
            state <= ISSUE;
            chunk.chunk_valid <= 1'b1;
            chunk.chunk_len <= clen;
            chunk.chunk_last <= lt;
          end
        end
        DRAIN: if (chunk.chunk_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_cmd_scheduler.sv
// tb_dma_cmd_scheduler: scoreboard bench for dma_cmd_scheduler chunking, queueing, flush and irq
module tb_dma_cmd_scheduler;
  logic clk = 0, reset_n = 0, new_cmd = 0, sclr = 0, clear_irq = 0;
  logic [63:0] src_start_addr = 0, dst_start_addr = 0, xfer_length = 0;
  logic [63:0] cmdq_status;
  logic busy, irq;
  logic [31:0] cmd_done_count;
  dma_cmd_scheduler_if #(.ADDR_W(64), .LEN_W(64)) ifc ();
  dma_cmd_scheduler dut (
    .clk(clk), .reset_n(reset_n), .new_cmd(new_cmd),
    .src_start_addr(src_start_addr), .dst_start_addr(dst_start_addr), .xfer_length(xfer_length),
    .sclr(sclr), .clear_irq(clear_irq), .chunk(ifc.master),
    .cmdq_status(cmdq_status), .busy(busy), .irq(irq), .cmd_done_count(cmd_done_count)
  );
  always #5 clk = ~clk;
  typedef struct {logic [63:0] s, d, l; logic last;} chunk_t;
  chunk_t exp_q[$];
  int n_chk = 0, n_pass = 0, cyc = 0, done_at = -1;
  logic auto_done = 1, man_done = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic send(input logic [63:0] s, input logic [63:0] d, input logic [63:0] l, input bit acc);
    logic [63:0] r, c;
    src_start_addr = s; dst_start_addr = d; xfer_length = l; new_cmd = 1;
    r = l;
    while (acc && r != 0) begin
      c = r > 4096 ? 64'd4096 : r;
      exp_q.push_back('{s, d, c, r <= 4096});
      s += c; d += c; r -= c;
    end
    tick();
    new_cmd = 0;
  endtask
  task automatic wait_last(input string tag);
    bit seen = 0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(posedge clk); #3;
      seen = ifc.chunk_done && ifc.chunk_last;
    end
    check({tag, "_last_done"}, 64'(seen), 1);
    check({tag, "_irq_before"}, 64'(irq), 0);
    tick();
  endtask
  task automatic wait_cnt(input logic [31:0] target);
    for (int i = 0; i < 3000 && cmd_done_count != target; i++) tick();
    check("done_count_reached", 64'(cmd_done_count), 64'(target));
  endtask
  task automatic pulse_clear();
    clear_irq = 1; tick(); clear_irq = 0;
  endtask
  always @(negedge clk) begin
    if (reset_n && ifc.chunk_valid && ifc.chunk_ready) begin
      check("sb_nonempty", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        chunk_t e;
        e = exp_q.pop_front();
        check("chunk_src", ifc.chunk_src, e.s);
        check("chunk_dst", ifc.chunk_dst, e.d);
        check("chunk_len", ifc.chunk_len, e.l);
        check("chunk_last", 64'(ifc.chunk_last), 64'(e.last));
      end
      if (auto_done) done_at = cyc + 5;
    end
  end
  initial begin
    ifc.chunk_done = 0;
    forever begin
      @(posedge clk); #2;
      cyc++;
      ifc.chunk_done = man_done | (cyc == done_at);
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    ifc.chunk_ready = 1;
    repeat (3) tick();
    check("rst_valid", 64'(ifc.chunk_valid), 0);
    check("rst_src", ifc.chunk_src, 0);
    check("rst_len", ifc.chunk_len, 0);
    check("rst_status", cmdq_status, 64'h1_0000_0000);
    check("rst_busy", 64'(busy), 0);
    check("rst_irq", 64'(irq), 0);
    reset_n = 1;
    tick();
    send(64'h1000, 64'h8000, 64'd10000, 1);
    wait_last("c10000");
    check("c10000_irq", 64'(irq), 1);
    check("c10000_cnt", 64'(cmd_done_count), 1);
    pulse_clear();
    check("irq_cleared", 64'(irq), 0);
    send(64'h10000, 64'h20000, 64'd8192, 1);
    wait_last("c8192");
    check("c8192_cnt", 64'(cmd_done_count), 2);
    pulse_clear();
    send(64'h30000, 64'h40000, 64'd1, 1);
    wait_last("c1");
    check("c1_cnt", 64'(cmd_done_count), 3);
    send(64'h5000, 64'h6000, 64'd0, 1);
    check("len0_status", cmdq_status, 64'h1_0000_0000);
    tick();
    check("len0_busy", 64'(busy), 0);
    ifc.chunk_ready = 0;
    send(64'h100000, 64'h900000, 64'd100, 1);
    send(64'h200000, 64'ha00000, 64'd200, 1);
    send(64'h300000, 64'hb00000, 64'd5000, 1);
    send(64'h400000, 64'hc00000, 64'd300, 1);
    check("q_count3", cmdq_status, 64'h0_0000_0003);
    send(64'h500000, 64'hd00000, 64'd400, 1);
    check("q_full", cmdq_status, 64'h2_0000_0004);
    send(64'h600000, 64'he00000, 64'd500, 0);
    check("q_overflow", cmdq_status, 64'h6_0000_0004);
    ifc.chunk_ready = 1;
    wait_cnt(8);
    tick();
    check("q_busy_after", 64'(busy), 0);
    check("q_status_after", cmdq_status, 64'h5_0000_0000);
    pulse_clear();
    auto_done = 0;
    send(64'h700000, 64'hf00000, 64'd100, 1);
    send(64'h710000, 64'hf10000, 64'd100, 0);
    send(64'h720000, 64'hf20000, 64'd100, 0);
    check("wait_q2", cmdq_status, 64'h4_0000_0002);
    sclr = 1; tick(); sclr = 0;
    check("sclr_status", cmdq_status, 64'h1_0000_0000);
    check("drain_busy", 64'(busy), 1);
    man_done = 1; tick(); man_done = 0;
    tick();
    check("drain_idle_busy", 64'(busy), 0);
    check("drain_irq", 64'(irq), 0);
    check("drain_cnt", 64'(cmd_done_count), 8);
    man_done = 1; tick(); man_done = 0;
    tick();
    check("stray_done_cnt", 64'(cmd_done_count), 8);
    check("stray_done_valid", 64'(ifc.chunk_valid), 0);
    send(64'h50000, 64'h60000, 64'd64, 1);
    repeat (3) tick();
    man_done = 1; clear_irq = 1; tick(); man_done = 0; clear_irq = 0;
    check("set_wins_irq", 64'(irq), 1);
    check("set_wins_cnt", 64'(cmd_done_count), 9);
    pulse_clear();
    check("clear_alone_irq", 64'(irq), 0);
    ifc.chunk_ready = 0;
    send(64'h70000, 64'h80000, 64'd100, 0);
    repeat (2) tick();
    check("pre_rst_valid", 64'(ifc.chunk_valid), 1);
    #2 reset_n = 0;
    #1;
    check("arst_valid", 64'(ifc.chunk_valid), 0);
    check("arst_status", cmdq_status, 64'h1_0000_0000);
    check("arst_cnt", 64'(cmd_done_count), 0);
    check("arst_busy", 64'(busy), 0);
    tick();
    reset_n = 1;
    tick();
    man_done = 1; tick(); man_done = 0;
    tick();
    check("post_rst_cnt", 64'(cmd_done_count), 0);
    check("post_rst_irq", 64'(irq), 0);
    check("post_rst_busy", 64'(busy), 0);
    check("sb_drained", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
